instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 126 ++++++++++++
 tb/tb_instr_encoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction-field encoder feeding an address-tagged output FIFO.
// Optional macro IMM_RANGE_CHECK_EN: drop bundles with out-of-range immediates and flag a sticky err.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_type,
    input  logic [4:0]               rd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [12:0]              imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        T_R  = 2'b00,
        T_LD = 2'b01,
        T_S  = 2'b10,
        T_SB = 2'b11
    } type_e;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   enc_word;
    logic          push;
    logic          pop;

    always_comb begin
        enc_word = 32'h0;
        case (type_e'(in_type))
            T_R:  enc_word = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
            T_LD: enc_word = {imm[11:0], rs1, funct3, rd, 7'b0000011};
            T_S:  enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            T_SB: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
            default: enc_word = 32'h0;
        endcase
    end

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_instr = mem_q[rd_ptr_q];
    assign out_addr  = addr_q;
    assign count     = count_q;
    assign pop       = out_valid & out_ready;

`ifdef IMM_RANGE_CHECK_EN
    logic imm_bad;
    logic err_q;

    always_comb begin
        imm_bad = 1'b0;
        case (type_e'(in_type))
            T_LD, T_S: imm_bad = (imm[12] != imm[11]);
            T_SB:      imm_bad = imm[0];
            default:   imm_bad = 1'b0;
        endcase
    end

    assign push = in_valid & in_ready & ~imm_bad;

    // Rejected bundles are still consumed (in_ready unaffected); only the flag records them.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (in_valid & in_ready & imm_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign push = in_valid & in_ready;
    assign err  = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        addr_d   = pop ? addr_q + 32'd4 : addr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_ADDR;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
        end
    end

    // Storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus random traffic against a queue model.
module tb_instr_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_type;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [12:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [2:0]  count;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mq[$];
    logic [31:0] exp_addr;
    logic        exp_err;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .count(count), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference encoding built from field weights rather than bit concatenation.
    function automatic logic [31:0] ref_enc(input int t, input int d, input int s1, input int s2,
                                            input int f3, input int f7, input int im);
        longint w;
        longint common;
        common = longint'(s1) * (2**15) + longint'(f3) * (2**12);
        case (t)
            0: w = longint'(f7) * (2**25) + longint'(s2) * (2**20) + common + d * 128 + 51;
            1: w = longint'(im % 4096) * (2**20) + common + d * 128 + 3;
            2: w = longint'((im % 4096) / 32) * (2**25) + longint'(s2) * (2**20) + common
                   + (im % 32) * 128 + 35;
            default: w = longint'(im / 4096) * 64'h8000_0000 + longint'((im / 32) % 64) * (2**25)
                   + longint'(s2) * (2**20) + common + ((im / 2) % 16) * 256
                   + ((im / 2048) % 2) * 128 + 99;
        endcase
        return w[31:0];
    endfunction

    function automatic bit ref_bad(input int t, input int im);
        if (t == 1 || t == 2) return ((im / 4096) % 2) != ((im / 2048) % 2);
        if (t == 3) return (im % 2) == 1;
        return 1'b0;
    endfunction

    task automatic drive(input bit v, input int t, input int d, input int s1, input int s2,
                         input int f3, input int f7, input int im, input bit ordy);
        in_valid  = v;
        in_type   = 2'(t);
        rd        = 5'(d);
        rs1       = 5'(s1);
        rs2       = 5'(s2);
        funct3    = 3'(f3);
        funct7    = 7'(f7);
        imm       = 13'(im);
        out_ready = ordy;
    endtask

    task automatic check_outputs();
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
        chk("err", 32'(err), 32'(exp_err));
        chk("out_addr", out_addr, exp_addr);
        if (mq.size() != 0) chk("out_instr", out_instr, mq[0]);
    endtask

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic tick();
        bit          bad, accept, push, pop;
        logic [31:0] w;
        bad = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        bad = ref_bad(int'(in_type), int'(imm));
`endif
        accept = in_valid && (mq.size() != DEPTH);
        push   = accept && !bad;
        pop    = (mq.size() != 0) && out_ready;
        w = ref_enc(int'(in_type), int'(rd), int'(rs1), int'(rs2), int'(funct3), int'(funct7), int'(imm));
        @(posedge clk);
        if (rst) begin
            mq.delete();
            exp_addr = BASE;
            exp_err  = 1'b0;
        end else begin
            if (accept && bad) exp_err = 1'b1;
            if (pop) begin
                void'(mq.pop_front());
                exp_addr = exp_addr + 32'd4;
            end
            if (push) mq.push_back(w);
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        exp_addr = BASE;
        exp_err  = 1'b0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // R type
        drive(1, 0, 3, 1, 2, 0, 0, 0, 0);
        tick();
        chk("r_word", out_instr, 32'h002081B3);
        chk("r_addr", out_addr, BASE);

        // LD then S, behind the unpopped R
        drive(1, 1, 5, 6, 0, 2, 0, 8, 0);
        tick();
        drive(1, 2, 0, 6, 7, 2, 0, 12, 1);
        tick();
        chk("ld_word", out_instr, 32'h00832283);
        chk("ld_addr", out_addr, BASE + 32'd4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("s_word", out_instr, 32'h00732623);
        chk("s_addr", out_addr, BASE + 32'd8);
        tick();

        // SB with negative offset
        drive(1, 3, 0, 1, 2, 0, 0, 13'h1FF8, 0);
        tick();
        chk("sb_word", out_instr, 32'hFE208CE3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();

        // Fill, stall, then drain with the fifth bundle held
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, i + 1, i, i + 2, i, i, 0, 0);
            tick();
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        drive(1, 0, 5, 4, 6, 4, 4, 0, 0);
        tick();
        chk("full_hold_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        tick();
        tick();
        chk("fifth_accepted_count", 32'(count), 32'd3);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("drained_count", 32'(count), 32'd0);

        // Reset with three queued words, racing a push and pop
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, i, i, 0, 1, 0, i * 4, 0);
            tick();
        end
        chk("pre_rst_count", 32'(count), 32'd3);
        drive(1, 0, 9, 9, 9, 0, 0, 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_addr", out_addr, BASE);

        // LD with imm[12]!=imm[11]
        drive(1, 1, 0, 0, 0, 0, 0, 13'h0800, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef IMM_RANGE_CHECK_EN
        chk("bad_imm_count", 32'(count), 32'd0);
        chk("bad_imm_err", 32'(err), 32'd1);
        tick();
        tick();
        chk("err_sticky", 32'(err), 32'd1);
`else
        chk("trunc_word", out_instr, 32'h80000003);
        chk("trunc_err", 32'(err), 32'd0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
                  $urandom_range(0, 127), $urandom_range(0, 8191), $urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
